// File: rtl/multikey_debounce.sv
// multikey_debounce: per-key synchroniser, debounce and auto-repeat conditioner
// producing registered press/release/repeat pulses and a debounced held level.
module multikey_debounce #(
    parameter int NUM_KEYS      = 4,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int CNT_W         = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] rpt_en,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_repeat
);
    typedef enum logic [2:0] {IDLE, DEB_DN, HELD, REPEAT, DEB_UP} state_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_key
            logic [1:0]       sync;
            logic             s;
            state_t           st, st_nx;
            logic [CNT_W-1:0] cnt, cnt_nx;
            logic             press_nx, rel_nx, rep_nx;
            logic             press_q, rel_q, held_q, rep_q;

            assign s = sync[1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync    <= 2'b11;
                    st      <= IDLE;
                    cnt     <= '0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                    held_q  <= 1'b0;
                    rep_q   <= 1'b0;
                end else begin
                    sync    <= {sync[0], key_in[i]};
                    st      <= st_nx;
                    cnt     <= cnt_nx;
                    press_q <= press_nx;
                    rel_q   <= rel_nx;
                    held_q  <= st_nx inside {HELD, REPEAT, DEB_UP};
                    rep_q   <= rep_nx;
                end
            end

            // Saturating counters in HELD/REPEAT let a late rpt_en fire on the next edge.
            always_comb begin
                st_nx    = st;
                cnt_nx   = cnt;
                press_nx = 1'b0;
                rel_nx   = 1'b0;
                rep_nx   = 1'b0;
                case (st)
                    IDLE: if (!s) begin
                        st_nx  = DEB_DN;
                        cnt_nx = '0;
                    end
                    DEB_DN: if (s) st_nx = IDLE;
                    else if (cnt == DEB_MAX) begin
                        st_nx    = HELD;
                        cnt_nx   = '0;
                        press_nx = 1'b1;
                    end else cnt_nx = cnt + ONE;
                    HELD: if (s) begin
                        st_nx  = DEB_UP;
                        cnt_nx = '0;
                    end else if (cnt != DLY_MAX) cnt_nx = cnt + ONE;
                    else if (rpt_en[i]) begin
                        st_nx  = REPEAT;
                        cnt_nx = '0;
                        rep_nx = 1'b1;
                    end
                    REPEAT: if (s) begin
                        st_nx  = DEB_UP;
                        cnt_nx = '0;
                    end else if (cnt != PER_MAX) cnt_nx = cnt + ONE;
                    else if (rpt_en[i]) begin
                        cnt_nx = '0;
                        rep_nx = 1'b1;
                    end
                    DEB_UP: if (!s) begin
                        st_nx  = HELD;
                        cnt_nx = '0;
                    end else if (cnt == DEB_MAX) begin
                        st_nx  = IDLE;
                        cnt_nx = '0;
                        rel_nx = 1'b1;
                    end else cnt_nx = cnt + ONE;
                    default: begin
                        st_nx  = IDLE;
                        cnt_nx = '0;
                    end
                endcase
            end

            assign key_press[i]   = press_q;
            assign key_release[i] = rel_q;
            assign key_held[i]    = held_q;
            assign key_repeat[i]  = rep_q;
        end
    endgenerate
endmodule

// File: tb/tb_multikey_debounce.sv
// tb_multikey_debounce: scoreboard bench; a run-length reference model predicts
// every cycle's outputs, a negedge monitor pops and compares.
module tb_multikey_debounce;
    localparam int NK = 4, D = 8, RD = 40, RP = 10;
    typedef logic [4*NK-1:0] vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NK-1:0] key_in = '1, rpt_en = '0;
    logic [NK-1:0] key_press, key_release, key_held, key_repeat;

    always #5 clk = ~clk;

    multikey_debounce #(.NUM_KEYS(NK), .DEB_CYCLES(D), .REPEAT_DELAY(RD),
                        .REPEAT_PERIOD(RP), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .rpt_en(rpt_en),
        .key_press(key_press), .key_release(key_release),
        .key_held(key_held), .key_repeat(key_repeat));

    vec_t exp_q[$];
    int tests = 0, fails = 0;
    int press_cnt[NK], rel_cnt[NK], rep_cnt[NK];
    // model: 2-sample delay, run length of seen level, edges since repeat anchor
    int m_sa[NK], m_sb[NK], m_held[NK], m_run[NK], m_last[NK], m_e[NK], m_due[NK], m_brk[NK];

    always @(posedge clk) begin : model
        logic [NK-1:0] p, r, h, q;
        int s;
        p = '0; r = '0; h = '0; q = '0;
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                m_sa[k] = 1; m_sb[k] = 1; m_held[k] = 0; m_run[k] = 0; m_last[k] = 1;
                m_e[k] = 0; m_due[k] = RD; m_brk[k] = 0;
            end else begin
                s = m_sb[k];
                m_sb[k] = m_sa[k];
                m_sa[k] = int'(key_in[k]);
                m_run[k] = (s == m_last[k]) ? (m_run[k] < 1000 ? m_run[k] + 1 : 1000) : 1;
                m_last[k] = s;
                if (m_held[k] == 0 && s == 0 && m_run[k] == D + 1) begin
                    p[k] = 1'b1; m_held[k] = 1; m_e[k] = 0; m_due[k] = RD; m_brk[k] = 0;
                end else if (m_held[k] == 1 && s == 1 && m_run[k] == D + 1) begin
                    r[k] = 1'b1; m_held[k] = 0;
                end else if (m_held[k] == 1) begin
                    if (s == 1) m_brk[k] = 1;
                    else if (m_brk[k] == 1) begin
                        m_brk[k] = 0; m_e[k] = 0; m_due[k] = RD;
                    end else begin
                        m_e[k]++;
                        if (rpt_en[k] && m_e[k] >= m_due[k]) begin
                            q[k] = 1'b1; m_e[k] = 0; m_due[k] = RP;
                        end
                    end
                end
            end
            h[k] = (m_held[k] == 1);
        end
        exp_q.push_back({p, r, h, q});
    end

    always @(negedge clk) begin : monitor
        vec_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {key_press, key_release, key_held, key_repeat};
            if (!rst_n) e = '0;
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs t=%0t act=%h exp=%h (press,release,held,repeat)", $time, a, e);
            end
            for (int k = 0; k < NK; k++) begin
                press_cnt[k] += int'(key_press[k]);
                rel_cnt[k]   += int'(key_release[k]);
                rep_cnt[k]   += int'(key_repeat[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    initial begin
        int b;
        int hold[NK];
        step(3);
        rst_n = 1'b1;
        step(5);
        // 1: single clean press/release on key 0
        b = press_cnt[0];
        key_in[0] = 1'b0; step(100);
        key_in[0] = 1'b1; step(30);
        check("t1_press_count", press_cnt[0] - b, 1);
        check("t1_release_count", rel_cnt[0], 1);
        // 2: bounce then settle on key 1
        b = press_cnt[1];
        repeat (6) begin
            key_in[1] = 1'b0; step(5);
            key_in[1] = 1'b1; step(3);
        end
        check("t2_no_press_in_bounce", press_cnt[1] - b, 0);
        key_in[1] = 1'b0; step(20);
        check("t2_single_press", press_cnt[1] - b, 1);
        key_in[1] = 1'b1; step(30);
        // 3: auto-repeat on key 2
        rpt_en[2] = 1'b1;
        b = rep_cnt[2];
        key_in[2] = 1'b0; step(100);
        key_in[2] = 1'b1; step(30);
        check("t3_repeats", rep_cnt[2] - b, 6);
        // 4: repeat disabled, then enabled late
        rpt_en[2] = 1'b0;
        b = rep_cnt[2];
        key_in[2] = 1'b0; step(71);
        check("t4_no_repeat_disabled", rep_cnt[2] - b, 0);
        rpt_en[2] = 1'b1; step(15);
        key_in[2] = 1'b1; step(30);
        check("t4_late_repeats", rep_cnt[2] - b, 2);
        rpt_en[2] = 1'b0;
        // 5: simultaneous press, glitch while held
        key_in[0] = 1'b0; key_in[3] = 1'b0; step(20);
        b = rel_cnt[3];
        key_in[3] = 1'b1; step(5);
        key_in[3] = 1'b0; step(20);
        check("t5_no_release", rel_cnt[3] - b, 0);
        check("t5_held3", int'(key_held[3]), 1);
        key_in[0] = 1'b1; key_in[3] = 1'b1; step(30);
        // 6: reset while held
        key_in[0] = 1'b0; step(30);
        rst_n = 1'b0; #1;
        check("t6_reset_outs", int'({key_press, key_release, key_held, key_repeat}), 0);
        step(3);
        rst_n = 1'b1;
        b = press_cnt[0];
        step(20);
        check("t6_press_after_reset", press_cnt[0] - b, 1);
        key_in[0] = 1'b1; step(30);
        // random bouncing and rpt_en toggling
        for (int k = 0; k < NK; k++) hold[k] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (--hold[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    hold[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8))
                                                          : int'($urandom_range(9, 120));
                end
                if ($urandom_range(0, 60) == 0) rpt_en[k] = ~rpt_en[k];
            end
            step(1);
        end
        key_in = '1; step(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
